// File: rtl/ring_osc_meas_ctrl.sv
// Sequential ring-oscillator frequency meter: enables one oscillator at a time,
// lets it settle, counts synchronized rising edges over a fixed gate window and reports the count.
module ring_osc_meas_ctrl #(
  parameter int N_OSC         = 8,
  parameter int CNT_W         = 16,
  parameter int GATE_CYCLES   = 12000,
  parameter int SETTLE_CYCLES = 16,
  localparam int IDX_W        = (N_OSC > 1) ? $clog2(N_OSC) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_OSC-1:0] ring_in,
  input  logic [N_OSC-1:0] chan_mask,
  input  logic             start,
  input  logic             continuous,
  output logic [N_OSC-1:0] osc_en,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic [IDX_W-1:0] result_idx,
  output logic             result_ovf,
  output logic             result_valid
);

  localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, GATE, STORE} state_e;

  state_e             state_q, state_d;
  logic [N_OSC-1:0]   mask_q, mask_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [1:0]         sync_q, sync_d;
  logic               hist_q, hist_d;
  logic [CNT_W-1:0]   res_q, res_d;
  logic [IDX_W-1:0]   res_idx_q, res_idx_d;
  logic               res_ovf_q, res_ovf_d;

  logic               start_hit, next_hit, tmr_done, rise;
  logic [IDX_W-1:0]   start_idx, wrap_idx, next_idx;

  // Downward scans leave the lowest qualifying index as the final assignment.
  always_comb begin
    start_hit = 1'b0;
    next_hit  = 1'b0;
    start_idx = '0;
    wrap_idx  = '0;
    next_idx  = '0;
    for (int i = N_OSC - 1; i >= 0; i--) begin
      if (chan_mask[i]) begin
        start_hit = 1'b1;
        start_idx = IDX_W'(i);
      end
      if (mask_q[i]) wrap_idx = IDX_W'(i);
      if (mask_q[i] && i > int'(sel_q)) begin
        next_hit = 1'b1;
        next_idx = IDX_W'(i);
      end
    end
  end

  assign tmr_done = ((state_q == SETTLE) && (tmr_q == TMR_W'(SETTLE_CYCLES - 1))) ||
                    ((state_q == GATE)   && (tmr_q == TMR_W'(GATE_CYCLES - 1)));
  assign rise     = sync_q[1] & ~hist_q;

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && start_hit) state_d = SETTLE;
      SETTLE:  if (tmr_done) state_d = GATE;
      GATE:    if (tmr_done) state_d = STORE;
      STORE:   state_d = (next_hit || continuous) ? SETTLE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    osc_en = '0;
    if (state_q != IDLE) osc_en[sel_q] = 1'b1;
    busy         = (state_q != IDLE);
    result_valid = (state_q == STORE);
  end

  // NOTE: every comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    mask_d    = mask_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    res_d     = res_q;
    res_idx_d = res_idx_q;
    res_ovf_d = res_ovf_q;
    sync_d    = {sync_q[0], ring_in[sel_q]};
    // Tracking the synchronized level every cycle primes the history flop when the gate opens.
    hist_d    = sync_q[1];
    tmr_d     = '0;
    if ((state_q == SETTLE || state_q == GATE) && !tmr_done) tmr_d = tmr_q + TMR_W'(1);

    unique case (state_q)
      IDLE: begin
        if (start && start_hit) begin
          mask_d = chan_mask;
          sel_d  = start_idx;
        end
      end
      GATE: begin
        if (rise) begin
          if (cnt_q == CNT_MAX) ovf_d = 1'b1;
          else                  cnt_d = cnt_q + CNT_W'(1);
        end
        // Capture includes an edge seen on the final gate cycle.
        if (tmr_done) begin
          res_d     = cnt_d;
          res_ovf_d = ovf_d;
          res_idx_d = sel_q;
        end
      end
      STORE: begin
        cnt_d = '0;
        ovf_d = 1'b0;
        sel_d = next_hit ? next_idx : wrap_idx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mask_q    <= '0;
      sel_q     <= '0;
      tmr_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      sync_q    <= '0;
      hist_q    <= 1'b0;
      res_q     <= '0;
      res_idx_q <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      mask_q    <= mask_d;
      sel_q     <= sel_d;
      tmr_q     <= tmr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      sync_q    <= sync_d;
      hist_q    <= hist_d;
      res_q     <= res_d;
      res_idx_q <= res_idx_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  assign result     = res_q;
  assign result_idx = res_idx_q;
  assign result_ovf = res_ovf_q;

endmodule

// File: doc/ring_osc_meas_ctrl.md
RING_OSC_MEAS_CTRL -- requirements
Module: ring_osc_meas_ctrl

Interface
REQ-001 Parameter N_OSC, default 8: number of ring-oscillator channels measured.
REQ-002 Parameter CNT_W, default 16: edge-counter and result width.
REQ-003 Parameter GATE_CYCLES, default 12000: gate window in CLK cycles (1 ms at 12 MHz).
REQ-004 Parameter SETTLE_CYCLES, default 16: oscillator start-up and synchronizer flush time in CLK cycles.
REQ-005 Port CLK, input, 1: the single clock; all state is updated on the rising edge.
REQ-006 Port RST, input, 1: reset, synchronous and active-high.
REQ-007 Port ring_in, input, N_OSC: pre-divided ring outputs, asynchronous to CLK, each below CLK/4.
REQ-008 Port chan_mask, input, N_OSC: channels included in a sweep; sampled on start.
REQ-009 Port start, input, 1: single-cycle request to begin a sweep.
REQ-010 Port continuous, input, 1: sweep repeats while high.
REQ-011 Port osc_en, output, N_OSC: one-hot enable for the oscillator under measurement; all-zero otherwise.
REQ-012 Port busy, output, 1: high in any state other than IDLE.
REQ-013 Port result, output, CNT_W: count of rising edges seen in the last gate window.
REQ-014 Port result_idx, output, 3 bits (clog2 N_OSC): channel index for result.
REQ-015 Port result_ovf, output, 1: the count saturated in that window.
REQ-016 Port result_valid, output, 1: single-cycle strobe qualifying result, result_idx and result_ovf.

Function
REQ-017 FSM SHALL have four states: IDLE, SETTLE, GATE, STORE.
REQ-018 IDLE: when start=1 and the sampled mask is non-zero, latch the mask, select its lowest set index and go to SETTLE next cycle.
REQ-019 IDLE: start with a zero mask SHALL be ignored; start while busy=1 SHALL be ignored.
REQ-020 SETTLE: osc_en is the one-hot of the selected index; selected ring_in feeds a 2-flop synchronizer plus an edge-detect flop; no counting; exactly SETTLE_CYCLES cycles, then GATE.
REQ-021 On the SETTLE->GATE transition, the edge-detect history flop SHALL be loaded with the current synchronized level, so no false edge is counted at gate open.
REQ-022 GATE: the counter SHALL increment on each synchronized 0->1 transition; it lasts exactly GATE_CYCLES cycles, then STORE.
REQ-023 The counter SHALL saturate at 2^CNT_W-1 and set an overflow flag; it SHALL never wrap.
REQ-024 STORE (1 cycle): result, result_idx and result_ovf are updated, and result_valid=1 for that cycle only; the counter and overflow flag are cleared.
REQ-025 After STORE: go to SETTLE with the next set mask bit above the current one; if none, and continuous=1, wrap to the lowest set bit of the latched mask; otherwise go to IDLE.
REQ-026 Latency: start accepted in cycle T gives the first result_valid in cycle T+SETTLE_CYCLES+GATE_CYCLES+1; each later channel follows SETTLE_CYCLES+GATE_CYCLES+1 cycles after the previous one.
REQ-027 Deasserting continuous mid-sweep SHALL finish the current pass, then return to IDLE; it is evaluated only at STORE.
REQ-028 Changing chan_mask while busy SHALL have no effect until the next accepted start.
REQ-029 osc_en SHALL be all-zero in IDLE and one-hot in SETTLE, GATE and STORE.
REQ-030 result, result_idx and result_ovf SHALL hold their value until the next STORE.

Reset
REQ-031 RST=1 at a rising CLK edge SHALL force IDLE, osc_en=0, busy=0, result_valid=0, result=0, result_idx=0, result_ovf=0, and clear the counter, synchronizer and latched mask.
REQ-032 RST asserted during any state SHALL abort the sweep with no result_valid strobe; a start in the first cycle after RST deasserts SHALL be accepted.

Verification (GATE_CYCLES=100, SETTLE_CYCLES=4, CNT_W=8)
REQ-033 Single channel: mask=8'h04, ring_in[2] with period 10 CLK, start at T -> osc_en=8'h04 from T+1; result_valid at T+105; result=10, result_idx=2, result_ovf=0; then IDLE.
REQ-034 Sweep: mask=8'h81, continuous=0 -> two strobes, idx 0 at T+105 and idx 7 at T+210; osc_en never has more than one bit set; busy=0 from T+211.
REQ-035 Saturation: CNT_W=4, period 4 CLK -> result=15, result_ovf=1; the next window with period 10 gives result_ovf=0.
REQ-036 Wrap/continuous: mask=8'h03, continuous=1 -> idx sequence 0,1,0,1,...; drop continuous during idx 0 -> final strobe is idx 1, then IDLE.
REQ-037 Reset and ignore: RST pulsed mid-GATE -> no strobe and all outputs 0 the next cycle; start with mask=0, or start while busy -> no state change.
